// File: rtl/fsqrt_arbiter.sv
// ---------------------------------------------------------------------------
// fsqrt_arbiter
//
// Sequencing controller and two-port round-robin arbiter in front of a single
// shared two-stage fsqrt unit. Two requesters present operands over
// valid/ready; one operation is in flight at a time. The issued operand is
// held on fsqrt_s for the whole evaluation, the result is sampled after the
// fixed pipeline latency and parked in a one-entry buffer belonging to the
// requester that issued it, together with that request's tag.
//
// Parameters
//   LATENCY  register stages inside the fsqrt unit (>= 1)
//   TAG_W    width of the opaque requester tag
//
// Ports
//   clk                      clock, all state on the rising edge
//   rstn                     asynchronous active-low reset
//   req{0,1}_valid/_ready    request handshake (ready is combinational)
//   req{0,1}_data/_tag       single-precision operand and tag
//   fsqrt_s                  operand to the fsqrt unit (registered)
//   fsqrt_d                  result from the fsqrt unit
//   resp{0,1}_valid/_ready   response handshake (valid is registered)
//   resp{0,1}_data/_tag      result and the tag of the producing request
//   busy                     high while an operation is being evaluated
// ---------------------------------------------------------------------------
module fsqrt_arbiter #(
    parameter int LATENCY = 1,
    parameter int TAG_W   = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_data,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_data,
    input  logic [TAG_W-1:0] req1_tag,
    output logic [31:0]      fsqrt_s,
    input  logic [31:0]      fsqrt_d,
    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic [31:0]      resp0_data,
    output logic [TAG_W-1:0] resp0_tag,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [31:0]      resp1_data,
    output logic [TAG_W-1:0] resp1_tag,
    output logic             busy
);

    // Counter wide enough to hold LATENCY itself.
    localparam int CNT_W = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

    state_t             state_r;
    logic [31:0]        op_r;
    logic               id_r;
    logic [TAG_W-1:0]   tag_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               last_r;
    logic               busy_r;

    logic               resp0_valid_r;
    logic [31:0]        resp0_data_r;
    logic [TAG_W-1:0]   resp0_tag_r;
    logic               resp1_valid_r;
    logic [31:0]        resp1_data_r;
    logic [TAG_W-1:0]   resp1_tag_r;

    logic               elig0_s;
    logic               elig1_s;
    logic               grant0_s;
    logic               grant1_s;
    logic               done_s;

    // A requester may only issue when its result buffer is empty. The
    // registered valid is used, so a buffer draining this cycle does not
    // make its owner eligible until the next cycle.
    assign elig0_s = req0_valid && !resp0_valid_r;
    assign elig1_s = req1_valid && !resp1_valid_r;

    // The last cycle of evaluation: fsqrt_d is sampled at its end.
    assign done_s = (state_r == ST_EXEC) && (cnt_r == {CNT_W{1'b0}});

    // Grant selection in IDLE: a lone eligible requester wins, a tie goes to
    // the requester that was not granted last.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (state_r == ST_IDLE) begin
            if (elig0_s && elig1_s) begin
                if (last_r) begin
                    grant0_s = 1'b1;
                end else begin
                    grant1_s = 1'b1;
                end
            end else if (elig0_s) begin
                grant0_s = 1'b1;
            end else if (elig1_s) begin
                grant1_s = 1'b1;
            end else begin
                grant0_s = 1'b0;
                grant1_s = 1'b0;
            end
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    // Sequencer: issue capture, latency countdown and return to IDLE.
    // op_r changes only on an accepted request, so fsqrt_s stays put for
    // the whole evaluation.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
            op_r    <= 32'h0000_0000;
            id_r    <= 1'b0;
            tag_r   <= {TAG_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            last_r  <= 1'b1;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant0_s) begin
                        op_r    <= req0_data;
                        id_r    <= 1'b0;
                        tag_r   <= req0_tag;
                        cnt_r   <= CNT_W'(LATENCY);
                        last_r  <= 1'b0;
                        busy_r  <= 1'b1;
                        state_r <= ST_EXEC;
                    end else if (grant1_s) begin
                        op_r    <= req1_data;
                        id_r    <= 1'b1;
                        tag_r   <= req1_tag;
                        cnt_r   <= CNT_W'(LATENCY);
                        last_r  <= 1'b1;
                        busy_r  <= 1'b1;
                        state_r <= ST_EXEC;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r   <= cnt_r - CNT_W'(1);
                        busy_r  <= 1'b1;
                        state_r <= ST_EXEC;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Result buffer for requester 0. A capture can only target an empty
    // buffer (the owner was eligible at grant), so it never races a drain.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            resp0_valid_r <= 1'b0;
            resp0_data_r  <= 32'h0000_0000;
            resp0_tag_r   <= {TAG_W{1'b0}};
        end else if (done_s && (id_r == 1'b0)) begin
            resp0_valid_r <= 1'b1;
            resp0_data_r  <= fsqrt_d;
            resp0_tag_r   <= tag_r;
        end else if (resp0_ready) begin
            resp0_valid_r <= 1'b0;
        end else begin
            resp0_valid_r <= resp0_valid_r;
        end
    end

    // Result buffer for requester 1, same behaviour as buffer 0.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            resp1_valid_r <= 1'b0;
            resp1_data_r  <= 32'h0000_0000;
            resp1_tag_r   <= {TAG_W{1'b0}};
        end else if (done_s && (id_r == 1'b1)) begin
            resp1_valid_r <= 1'b1;
            resp1_data_r  <= fsqrt_d;
            resp1_tag_r   <= tag_r;
        end else if (resp1_ready) begin
            resp1_valid_r <= 1'b0;
        end else begin
            resp1_valid_r <= resp1_valid_r;
        end
    end

    // Ready has to answer in the grant cycle, so it comes straight from the
    // arbiter; every other output is a register.
    assign req0_ready  = grant0_s;
    assign req1_ready  = grant1_s;
    assign fsqrt_s     = op_r;
    assign busy        = busy_r;
    assign resp0_valid = resp0_valid_r;
    assign resp0_data  = resp0_data_r;
    assign resp0_tag   = resp0_tag_r;
    assign resp1_valid = resp1_valid_r;
    assign resp1_data  = resp1_data_r;
    assign resp1_tag   = resp1_tag_r;

endmodule

// File: tb/tb_fsqrt_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fsqrt_arbiter
//
// Directed bench for fsqrt_arbiter. A LATENCY=1 instance carries most
// scenarios, a LATENCY=3 instance checks the parameterised timing. Each
// fsqrt unit is modelled as a LATENCY-deep pipeline over a small square-root
// lookup table, so a result is only correct if fsqrt_s was held stable.
// Inputs are driven at the falling edge; outputs are checked 1 ns later.
// ---------------------------------------------------------------------------
module tb_fsqrt_arbiter;

    localparam int TAG_W = 5;

    logic             clk;
    logic             rstn;

    logic             req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0]      req0_data, req1_data;
    logic [TAG_W-1:0] req0_tag, req1_tag;
    logic [31:0]      fsqrt_s, fsqrt_d;
    logic             resp0_valid, resp1_valid, resp0_ready, resp1_ready;
    logic [31:0]      resp0_data, resp1_data;
    logic [TAG_W-1:0] resp0_tag, resp1_tag;
    logic             busy;

    logic             l3_req0_valid, l3_req1_valid, l3_req0_ready, l3_req1_ready;
    logic [31:0]      l3_req0_data, l3_req1_data;
    logic [TAG_W-1:0] l3_req0_tag, l3_req1_tag;
    logic [31:0]      l3_fsqrt_s, l3_fsqrt_d;
    logic             l3_resp0_valid, l3_resp1_valid, l3_resp0_ready, l3_resp1_ready;
    logic [31:0]      l3_resp0_data, l3_resp1_data;
    logic [TAG_W-1:0] l3_resp0_tag, l3_resp1_tag;
    logic             l3_busy;

    int n_chk;
    int n_fail;

    logic [31:0] pipe1_q;
    logic [31:0] pipe3_q [3];

    fsqrt_arbiter #(.LATENCY(1), .TAG_W(TAG_W)) u_dut (
        .clk(clk), .rstn(rstn),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_tag(req1_tag),
        .fsqrt_s(fsqrt_s), .fsqrt_d(fsqrt_d),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_data(resp0_data), .resp0_tag(resp0_tag),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_data(resp1_data), .resp1_tag(resp1_tag),
        .busy(busy)
    );

    fsqrt_arbiter #(.LATENCY(3), .TAG_W(TAG_W)) u_dut3 (
        .clk(clk), .rstn(rstn),
        .req0_valid(l3_req0_valid), .req0_ready(l3_req0_ready), .req0_data(l3_req0_data), .req0_tag(l3_req0_tag),
        .req1_valid(l3_req1_valid), .req1_ready(l3_req1_ready), .req1_data(l3_req1_data), .req1_tag(l3_req1_tag),
        .fsqrt_s(l3_fsqrt_s), .fsqrt_d(l3_fsqrt_d),
        .resp0_valid(l3_resp0_valid), .resp0_ready(l3_resp0_ready), .resp0_data(l3_resp0_data), .resp0_tag(l3_resp0_tag),
        .resp1_valid(l3_resp1_valid), .resp1_ready(l3_resp1_ready), .resp1_data(l3_resp1_data), .resp1_tag(l3_resp1_tag),
        .busy(l3_busy)
    );

    // Square roots of the operands used in this bench.
    function automatic logic [31:0] f_sqrt(input logic [31:0] x);
        case (x)
            32'h3F80_0000: f_sqrt = 32'h3F80_0000; // 1  -> 1
            32'h4080_0000: f_sqrt = 32'h4000_0000; // 4  -> 2
            32'h4110_0000: f_sqrt = 32'h4040_0000; // 9  -> 3
            32'h4180_0000: f_sqrt = 32'h4080_0000; // 16 -> 4
            32'h41C8_0000: f_sqrt = 32'h40A0_0000; // 25 -> 5
            32'h4210_0000: f_sqrt = 32'h40C0_0000; // 36 -> 6
            default:       f_sqrt = 32'hDEAD_BEEF;
        endcase
    endfunction

    // fsqrt unit models: LATENCY stages over the current s.
    always_ff @(posedge clk) begin
        pipe1_q    <= f_sqrt(fsqrt_s);
        pipe3_q[0] <= f_sqrt(l3_fsqrt_s);
        pipe3_q[1] <= pipe3_q[0];
        pipe3_q[2] <= pipe3_q[1];
    end
    assign fsqrt_d    = pipe1_q;
    assign l3_fsqrt_d = pipe3_q[2];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset();
        rstn = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = 32'h0; req1_data = 32'h0; req0_tag = '0; req1_tag = '0;
        resp0_ready = 1'b0; resp1_ready = 1'b0;
        l3_req0_valid = 1'b0; l3_req1_valid = 1'b0;
        l3_req0_data = 32'h0; l3_req1_data = 32'h0; l3_req0_tag = '0; l3_req1_tag = '0;
        l3_resp0_ready = 1'b1; l3_resp1_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_chk++; if ({req0_ready, req1_ready, resp0_valid, resp1_valid, busy} !== 5'b00000) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 00000", {req0_ready, req1_ready, resp0_valid, resp1_valid, busy}); end
        n_chk++; if ({fsqrt_s, resp0_data, resp1_data} !== 96'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", {fsqrt_s, resp0_data, resp1_data}); end
        n_chk++; if ({resp0_tag, resp1_tag} !== 10'h0) begin n_fail++; $display("FAIL reset_tag: got %h expected 0", {resp0_tag, resp1_tag}); end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_single_op();
        @(negedge clk);
        req0_valid = 1'b1; req0_data = 32'h4080_0000; req0_tag = 5'd3;
        #1;
        n_chk++; if ({req0_ready, req1_ready} !== 2'b10) begin n_fail++; $display("FAIL single_grant: got %b expected 10", {req0_ready, req1_ready}); end
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            req0_valid = 1'b0; req0_data = 32'h0;
            #1;
            n_chk++; if (fsqrt_s !== 32'h4080_0000) begin n_fail++; $display("FAIL single_s c%0d: got %h expected 40800000", c, fsqrt_s); end
            n_chk++; if ({busy, resp0_valid} !== 2'b10) begin n_fail++; $display("FAIL single_busy c%0d: got %b expected 10", c, {busy, resp0_valid}); end
        end
        @(negedge clk);
        resp0_ready = 1'b1;
        #1;
        n_chk++; if ({resp0_valid, busy} !== 2'b10) begin n_fail++; $display("FAIL single_rv: got %b expected 10", {resp0_valid, busy}); end
        n_chk++; if (resp0_data !== 32'h4000_0000) begin n_fail++; $display("FAIL single_data: got %h expected 40000000", resp0_data); end
        n_chk++; if (resp0_tag !== 5'd3) begin n_fail++; $display("FAIL single_tag: got %0d expected 3", resp0_tag); end
        @(negedge clk);
        resp0_ready = 1'b0;
        #1;
        n_chk++; if (resp0_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain: got %b expected 0", resp0_valid); end
    endtask

    task automatic test_simultaneous();
        // Fresh reset so the first tie goes to requester 0.
        @(negedge clk); rstn = 1'b0;
        @(negedge clk); rstn = 1'b1;
        @(negedge clk);
        req0_valid = 1'b1; req0_data = 32'h4110_0000; req0_tag = 5'd1;
        req1_valid = 1'b1; req1_data = 32'h4180_0000; req1_tag = 5'd2;
        #1;
        n_chk++; if ({req0_ready, req1_ready} !== 2'b10) begin n_fail++; $display("FAIL simul_first: got %b expected 10", {req0_ready, req1_ready}); end
        @(negedge clk); req0_valid = 1'b0; #1;
        n_chk++; if ({req0_ready, req1_ready} !== 2'b00) begin n_fail++; $display("FAIL simul_exec1: got %b expected 00", {req0_ready, req1_ready}); end
        @(negedge clk); #1;
        n_chk++; if ({req0_ready, req1_ready} !== 2'b00) begin n_fail++; $display("FAIL simul_exec2: got %b expected 00", {req0_ready, req1_ready}); end
        @(negedge clk); #1;
        n_chk++; if ({req0_ready, req1_ready} !== 2'b01) begin n_fail++; $display("FAIL simul_second: got %b expected 01", {req0_ready, req1_ready}); end
        n_chk++; if ({resp0_valid, resp0_data} !== {1'b1, 32'h4040_0000}) begin n_fail++; $display("FAIL simul_r0: got %b/%h expected 1/40400000", resp0_valid, resp0_data); end
        @(negedge clk); req1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        n_chk++; if ({resp1_valid, resp1_data, resp1_tag} !== {1'b1, 32'h4080_0000, 5'd2}) begin n_fail++; $display("FAIL simul_r1: got %b/%h/%0d expected 1/40800000/2", resp1_valid, resp1_data, resp1_tag); end
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        @(negedge clk); #1;
        n_chk++; if ({resp0_valid, resp1_valid} !== 2'b00) begin n_fail++; $display("FAIL simul_drain: got %b expected 00", {resp0_valid, resp1_valid}); end
    endtask

    task automatic test_round_robin();
        // Last grant went to requester 1, so requester 0 goes first.
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        @(negedge clk);
        req0_valid = 1'b1; req0_data = 32'h3F80_0000; req0_tag = 5'd4;
        req1_valid = 1'b1; req1_data = 32'h41C8_0000; req1_tag = 5'd5;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            n_chk++; if ({req0_ready, req1_ready} !== {(c % 6) == 0, (c % 6) == 3}) begin n_fail++; $display("FAIL rr_grant c%0d: got %b expected %b", c, {req0_ready, req1_ready}, {(c % 6) == 0, (c % 6) == 3}); end
            if ((c % 6) == 3) begin
                n_chk++; if ({resp0_valid, resp0_data} !== {1'b1, 32'h3F80_0000}) begin n_fail++; $display("FAIL rr_r0 c%0d: got %b/%h expected 1/3f800000", c, resp0_valid, resp0_data); end
            end
            if ((c % 6) == 0 && c > 0) begin
                n_chk++; if ({resp1_valid, resp1_data} !== {1'b1, 32'h40A0_0000}) begin n_fail++; $display("FAIL rr_r1 c%0d: got %b/%h expected 1/40a00000", c, resp1_valid, resp1_data); end
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_chk++; if ({resp0_valid, resp1_valid, busy} !== 3'b000) begin n_fail++; $display("FAIL rr_quiet: got %b expected 000", {resp0_valid, resp1_valid, busy}); end
    endtask

    task automatic test_backpressure();
        resp0_ready = 1'b0; resp1_ready = 1'b1;
        @(negedge clk);
        req0_valid = 1'b1; req0_data = 32'h41C8_0000; req0_tag = 5'd1;
        #1;
        n_chk++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL bp_first: got %b expected 1", req0_ready); end
        @(negedge clk);
        req0_data = 32'h4210_0000; req0_tag = 5'd2;
        @(negedge clk);
        @(negedge clk);
        req1_valid = 1'b1; req1_data = 32'h4110_0000; req1_tag = 5'd7;
        #1;
        n_chk++; if ({resp0_valid, resp0_data, resp0_tag} !== {1'b1, 32'h40A0_0000, 5'd1}) begin n_fail++; $display("FAIL bp_r0: got %b/%h/%0d expected 1/40a00000/1", resp0_valid, resp0_data, resp0_tag); end
        n_chk++; if ({req0_ready, req1_ready} !== 2'b01) begin n_fail++; $display("FAIL bp_other: got %b expected 01", {req0_ready, req1_ready}); end
        for (int c = 4; c <= 7; c++) begin
            @(negedge clk);
            req1_valid = 1'b0;
            #1;
            n_chk++; if ({req0_ready, resp0_valid, resp0_data} !== {2'b01, 32'h40A0_0000}) begin n_fail++; $display("FAIL bp_hold c%0d: got %b/%b/%h expected 0/1/40a00000", c, req0_ready, resp0_valid, resp0_data); end
            if (c == 6) begin
                n_chk++; if ({resp1_valid, resp1_data, resp1_tag} !== {1'b1, 32'h4040_0000, 5'd7}) begin n_fail++; $display("FAIL bp_r1: got %b/%h/%0d expected 1/40400000/7", resp1_valid, resp1_data, resp1_tag); end
            end
        end
        @(negedge clk);
        resp0_ready = 1'b1;
        #1;
        n_chk++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL bp_drain_cycle: got %b expected 0", req0_ready); end
        @(negedge clk);
        resp0_ready = 1'b0;
        #1;
        n_chk++; if ({resp0_valid, req0_ready} !== 2'b01) begin n_fail++; $display("FAIL bp_second: got %b expected 01", {resp0_valid, req0_ready}); end
        @(negedge clk); req0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        n_chk++; if ({resp0_valid, resp0_data, resp0_tag} !== {1'b1, 32'h40C0_0000, 5'd2}) begin n_fail++; $display("FAIL bp_r0b: got %b/%h/%0d expected 1/40c00000/2", resp0_valid, resp0_data, resp0_tag); end
        resp0_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        @(negedge clk);
        req1_valid = 1'b1; req1_data = 32'h4080_0000; req1_tag = 5'd9;
        @(negedge clk);
        req1_valid = 1'b0;
        #1;
        n_chk++; if ({busy, fsqrt_s} !== {1'b1, 32'h4080_0000}) begin n_fail++; $display("FAIL mid_issued: got %b/%h expected 1/40800000", busy, fsqrt_s); end
        rstn = 1'b0;
        #1;
        n_chk++; if ({busy, resp0_valid, resp1_valid, req0_ready, req1_ready} !== 5'b00000) begin n_fail++; $display("FAIL mid_async_ctrl: got %b expected 00000", {busy, resp0_valid, resp1_valid, req0_ready, req1_ready}); end
        n_chk++; if ({fsqrt_s, resp0_data, resp1_data} !== 96'h0) begin n_fail++; $display("FAIL mid_async_data: got %h expected 0", {fsqrt_s, resp0_data, resp1_data}); end
        @(negedge clk);
        rstn = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            n_chk++; if ({resp0_valid, resp1_valid, busy} !== 3'b000) begin n_fail++; $display("FAIL mid_ghost c%0d: got %b expected 000", c, {resp0_valid, resp1_valid, busy}); end
        end
        @(negedge clk);
        req0_valid = 1'b1; req0_data = 32'h4110_0000; req0_tag = 5'd6;
        req1_valid = 1'b1; req1_data = 32'h4180_0000; req1_tag = 5'd8;
        #1;
        n_chk++; if ({req0_ready, req1_ready} !== 2'b10) begin n_fail++; $display("FAIL mid_after_grant: got %b expected 10", {req0_ready, req1_ready}); end
        @(negedge clk); req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        n_chk++; if ({resp0_valid, resp0_data, resp0_tag} !== {1'b1, 32'h4040_0000, 5'd6}) begin n_fail++; $display("FAIL mid_after_resp: got %b/%h/%0d expected 1/40400000/6", resp0_valid, resp0_data, resp0_tag); end
        @(negedge clk);
    endtask

    task automatic test_latency3();
        @(negedge clk);
        l3_req0_valid = 1'b1; l3_req0_data = 32'h41C8_0000; l3_req0_tag = 5'd11;
        #1;
        n_chk++; if (l3_req0_ready !== 1'b1) begin n_fail++; $display("FAIL l3_grant: got %b expected 1", l3_req0_ready); end
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            l3_req0_valid = 1'b0; l3_req0_data = 32'h0;
            #1;
            n_chk++; if ({l3_fsqrt_s, l3_busy, l3_resp0_valid} !== {32'h41C8_0000, 2'b10}) begin n_fail++; $display("FAIL l3_hold c%0d: got %h/%b/%b expected 41c80000/1/0", c, l3_fsqrt_s, l3_busy, l3_resp0_valid); end
        end
        @(negedge clk); #1;
        n_chk++; if ({l3_resp0_valid, l3_resp0_data, l3_resp0_tag, l3_busy} !== {1'b1, 32'h40A0_0000, 5'd11, 1'b0}) begin n_fail++; $display("FAIL l3_resp: got %b/%h/%0d/%b expected 1/40a00000/11/0", l3_resp0_valid, l3_resp0_data, l3_resp0_tag, l3_busy); end
        @(negedge clk);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        test_reset();
        test_single_op();
        test_simultaneous();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_latency3();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fsqrt_arbiter.md
# fsqrt_arbiter

Sequencing controller and two-port arbiter for the shared two-stage `fsqrt` unit. It accepts square-root requests from two independent requesters over valid/ready, and grants them round-robin. It holds the issued operand stable on the unit's `s` input for the whole evaluation and captures the result after the fixed pipeline latency. The result is returned to the originating requester with its tag. It sits between the FPU issue logic and a single `fsqrt` instance.

## Interface
- `LATENCY`, 1: register stages inside the `fsqrt` unit; legal values ≥1.
- `TAG_W`, 5: width of the requester tag carried with each operation.

- `clk`  in  1  clock, all state on rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `req0_valid` / `req1_valid`  in  1  request pending from requester 0 / 1.
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle.
- `req0_data` / `req1_data`  in  32  IEEE-754 single operand.
- `req0_tag` / `req1_tag`  in  TAG_W  opaque tag.
- `fsqrt_s`  out  32  operand to `fsqrt.s`.
- `fsqrt_d`  in  32  result from `fsqrt.d`.
- `resp0_valid` / `resp1_valid`  out  1  result available.
- `resp0_ready` / `resp1_ready`  in  1  requester consumes result.
- `resp0_data` / `resp1_data`  out  32  square-root result.
- `resp0_tag` / `resp1_tag`  out  TAG_W  tag of the request that produced the result.
- `busy`  out  1  high while in EXEC.

## Operation
- `fsqrt` evaluates its second stage from the current `s`. Therefore `fsqrt_s` must remain unchanged from the cycle after issue until the result is sampled. Only one operation is in flight at a time.
- `fsqrt_s` is driven from register `op_r`. `op_r` changes only on an accepted request.
- Requester i is eligible when `reqi_valid` is high and its result buffer is empty.
- Result buffers are one entry per requester: `respi_valid`, `respi_data`, `respi_tag`.
- **States:**
  - **IDLE:**
    - If exactly one requester is eligible, grant it.
    - If both are eligible, grant the one not in `last_r`.
    - On a grant:
      - `reqi_ready`=1 combinationally in the same cycle.
      - Load `op_r`←data, `id_r`←i, `tag_r`←tag, `cnt_r`←LATENCY, `last_r`←i.
      - Go to EXEC.
    - If nothing is eligible, both readys are 0 and the state stays IDLE.
  - **EXEC:**
    - While `cnt_r`≠0, decrement `cnt_r`.
    - When `cnt_r`==0:
      - Write `fsqrt_d` into buffer `id_r` along with `tag_r`.
      - Set `respi_valid`.
      - Go to IDLE.
    - Both readys are 0 throughout EXEC.
- **Result buffers:**
  - `respi_valid` clears on the cycle `respi_ready` is high.
  - A buffer that drains in the same cycle as IDLE arbitration does not make its requester eligible in that cycle. Eligibility uses the registered valid.
- Data is passed through unchanged. The controller never inspects the sign, NaN or zero encodings.
- **Reset (asynchronous, any state):**
  - State←IDLE; `op_r`, `cnt_r`, `id_r`, `tag_r` ←0; `last_r`←1, so requester 0 wins first.
  - All `respi_valid`←0.
  - An in-flight operation is discarded and never reported.

## Timing
- Reset values: `req*_ready`=0, `resp*_valid`=0, `resp*_data`=0, `resp*_tag`=0, `fsqrt_s`=0, `busy`=0.
- Handshake is accepted in cycle T, with `reqi_valid && reqi_ready`.
- `fsqrt_s` holds the operand from T+1 through T+1+LATENCY.
- `fsqrt_d` is sampled at the end of cycle T+1+LATENCY.
- `respi_valid` is first high in cycle T+2+LATENCY. Request-to-response latency is LATENCY+2; with LATENCY=1 it is 3.
- The earliest next acceptance is cycle T+2+LATENCY, so peak throughput is one op per LATENCY+2 cycles.
- `busy` is high in cycles T+1 .. T+1+LATENCY.
- Requester inputs are ignored outside the IDLE grant cycle. A requester deasserting valid before its grant loses nothing.
- A result is held stable while `respi_valid && !respi_ready`. The other requester may still be issued and completed.

## Test plan
- Single op, LATENCY=1:
  - Stimulus: req0 issues 0x40800000 (4.0) with tag 3 at cycle 10.
  - Required response:
    - `fsqrt_s`=0x40800000 in cycles 11–12.
    - `resp0_valid` rises at cycle 13 with data 0x40000000 and tag 3.
    - `busy` is high in cycles 11–12.
- Simultaneous requests right after reset:
  - Stimulus: req0=0x41100000 (9.0), req1=0x41800000 (16.0), both valid in cycle 5.
  - Required response:
    - req0 is granted in cycle 5 and returns 0x40400000.
    - req1 is granted at cycle 8 and returns 0x40800000 at cycle 11.
- Round-robin fairness:
  - Stimulus: both requesters held valid continuously, with resp_ready held at 1.
  - Required response: grants alternate 0,1,0,1 exactly, one grant every 3 cycles.
- Backpressure:
  - Stimulus: `resp0_ready`=0 while req0 issues twice.
  - Required response:
    - The second req0 request is not accepted while `resp0_valid` holds.
    - req1 ops still complete.
    - After `resp0_ready` is pulsed, the second req0 is accepted no earlier than the following cycle.
- Reset mid-operation:
  - Stimulus: assert `rstn`=0 in the cycle after issue.
  - Required response:
    - All outputs return to 0 immediately, asynchronously.
    - No response appears after release.
    - The next request after release completes normally.
- LATENCY=3 parameterisation:
  - Stimulus: a single op accepted at cycle T.
  - Required response:
    - `resp_valid` rises at T+5.
    - `fsqrt_s` stays constant for 4 cycles.
